prng_arbiter: RTL and testbench
===============================

# prng_arbiter

Shares one free-running PRNG output word stream among N requesters. After reset it discards a fixed number of warm-up words, then grants at most one requester per cycle with round-robin fairness. Each granted requester receives a distinct, never-reused random word. The block sits between the PRNG datapath (one new word every clock) and the consumers that need random numbers.

## Interface
Parameters:
- N, 4, number of requesters (2..16)
- Wout, 32, random word width; matches the PRNG output width
- WARMUP, 16, number of PRNG words discarded after reset (0..65535)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- rnd_in  in  Wout  PRNG output word; a new word is presented every cycle
- req  in  N  per-requester request level; held high until granted
- gnt  out  N  one-hot grant pulse, registered
- rnd_out  out  Wout  random word for the requester granted this cycle, registered
- ready  out  1  high once warm-up is complete
- grant_total  out  32  total grants since reset; present only with PRNG_ARB_STATS_EN

## Operation
- Reset values: gnt=0, rnd_out=0, ready=0, grant_total=0, round-robin pointer ptr=0, warm-up counter=0.
- State WARMUP:
  - Counter increments every cycle; no grants.
  - When counter == WARMUP-1, next state is RUN and ready<=1.
  - WARMUP=0: the block enters RUN on the first cycle after rst deasserts.
- State RUN:
  - Eligibility mask: elig = req & ~gnt. A requester whose gnt is high this cycle is not eligible, so one request cannot be granted twice.
  - Winner: the first set bit of elig, scanning from index ptr upward and wrapping modulo N.
  - If a winner exists: gnt<=onehot(winner), rnd_out<=rnd_in, ptr<=(winner+1) mod N.
  - If no winner: gnt<=0; rnd_out and ptr hold.
- Each rnd_in word is captured for at most one grant. Words in cycles without a grant are discarded.
- RUN persists until rst. There is no other exit.
- Requester contract: deassert req, or re-request, in the cycle after seeing gnt. A req still high in the gnt cycle is masked and becomes eligible again one cycle later.
- req bits are ignored in WARMUP; requests pending at the end of warm-up are arbitrated normally from the first RUN cycle.

## Timing
- Grant latency: gnt and rnd_out are valid 1 cycle after req is sampled high with no contention. Worst case is N cycles under full contention.
- rnd_out equals rnd_in as sampled on the edge that sets gnt.
- gnt is high for exactly one cycle per grant and has at most one bit set.
- ready rises on the edge that ends cycle WARMUP after rst deasserts, then stays high.
- Reset mid-operation: on the next edge with rst=1, all outputs return to reset values and ptr=0. Warm-up restarts and any pending grant is lost.
- grant_total increments on each cycle where gnt is nonzero and wraps at 2^32.

## Configuration
- PRNG_ARB_STATS_EN defined: the grant_total port and its 32-bit counter exist.
- PRNG_ARB_STATS_EN undefined: the port and counter are absent. Arbitration behaviour is identical.

## Test plan
- Warm-up: WARMUP=16, req=4'b1111 from reset release. Required: ready=0 and gnt=0 for 16 cycles; ready=1 at cycle 16; first grant gnt=4'b0001 at cycle 17 with rnd_out equal to rnd_in at the cycle-16 edge.
- Round robin: N=4, req held at 4'b1111, each requester re-asserting after its grant. Required: gnt sequence 0001,0010,0100,1000,0001; no requester skipped; no consecutive gnt bits in the same position.
- Sparse request: only req[2] pulsed high for one cycle at a time, repeatedly. Required: gnt=4'b0100 one cycle after each pulse; ptr moves to 3; a later req[1] alone is granted next cycle after wrap.
- Uniqueness: rnd_in driven as a cycle counter 0,1,2,…, all four req held high for 100 cycles. Required: every rnd_out value on grant cycles is distinct and strictly increasing.
- Reset mid-run: assert rst for 1 cycle during full contention. Required: gnt=0, rnd_out=0, ready=0 on the next edge; warm-up repeats; first grant after it goes to requester 0.
- Stats (PRNG_ARB_STATS_EN defined): 37 grants, then sample. Required: grant_total=37; grant_total=0 after rst.

Source files
------------

// File: rtl/prng_arbiter.sv
// prng_arbiter: hands out one fresh PRNG word per cycle to N requesters, round-robin, after a warm-up
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   rnd_in       : PRNG word presented every cycle
//   req          : per-requester request level
//   gnt          : registered one-hot grant pulse
//   rnd_out      : registered word for the requester granted this cycle
//   ready        : high once warm-up words have been discarded
//   grant_total  : grant count since reset, only when PRNG_ARB_STATS_EN is defined
module prng_arbiter #(
   parameter int N      = 4,
   parameter int Wout   = 32,
   parameter int WARMUP = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [Wout-1:0] rnd_in,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    gnt,
   output logic [Wout-1:0] rnd_out,
   output logic            ready
`ifdef PRNG_ARB_STATS_EN
   ,
   output logic [31:0]     grant_total
`endif
);
   localparam int PW = $clog2(N);
   localparam logic [0:0] ST_WARM = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
   localparam logic [15:0] LAST = 16'((WARMUP == 0) ? 0 : WARMUP - 1);
   logic [0:0]      state_q, state_d;
   logic [15:0]     cnt_q, cnt_d;
   logic [N-1:0]    gnt_q, gnt_d, elig;
   logic [Wout-1:0] rnd_q, rnd_d;
   logic [PW-1:0]   ptr_q, ptr_d, win;
   logic            found, grant;
   always_comb begin
      // a requester granted this cycle is masked so one request never wins twice
      elig  = req & ~gnt_q;
      found = 1'b0;
      win   = '0;
      // scan positions from the far end back to ptr so the nearest one at or after ptr wins
      for (int i = N - 1; i >= 0; i--) begin
         if (elig[PW'((int'(ptr_q) + i) % N)]) begin
            found = 1'b1;
            win   = PW'((int'(ptr_q) + i) % N);
         end
      end
      grant   = (state_q == ST_RUN) && found;
      state_d = (state_q == ST_WARM && (WARMUP == 0 || cnt_q == LAST)) ? ST_RUN : state_q;
      cnt_d   = (state_q == ST_WARM) ? cnt_q + 16'd1 : cnt_q;
      gnt_d   = grant ? N'(1) << win : '0;
      rnd_d   = grant ? rnd_in : rnd_q;
      ptr_d   = grant ? ((win == PW'(N - 1)) ? '0 : win + PW'(1)) : ptr_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_WARM;
         cnt_q   <= '0;
         gnt_q   <= '0;
         rnd_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         rnd_q   <= rnd_d;
         ptr_q   <= ptr_d;
      end
   end
   assign gnt     = gnt_q;
   assign rnd_out = rnd_q;
   assign ready   = (state_q == ST_RUN);
`ifdef PRNG_ARB_STATS_EN
   logic [31:0] total_q, total_d;
   always_comb total_d = total_q + 32'(|gnt_q);
   always_ff @(posedge clk) begin
      if (rst) total_q <= '0;
      else total_q <= total_d;
   end
   assign grant_total = total_q;
`endif
endmodule

// File: tb/tb_prng_arbiter.sv
// tb_prng_arbiter: scoreboard bench for prng_arbiter (N=4, Wout=32, WARMUP=16)
module tb_prng_arbiter;
   localparam int N = 4, W = 32, WU = 16;
   logic clk = 1'b0, rst = 1'b1;
   logic [W-1:0] rnd_in = '0;
   logic [N-1:0] req = '0;
   logic [N-1:0] gnt;
   logic [W-1:0] rnd_out;
   logic ready;
`ifdef PRNG_ARB_STATS_EN
   logic [31:0] grant_total;
`endif
   int n_cmp = 0, n_bad = 0;
   typedef struct packed {logic [N-1:0] g; logic [W-1:0] r; logic rdy;} exp_t;
   exp_t sb[$];
   exp_t e;
   logic [N-1:0] prev_g;
   logic [W-1:0] prev_r;
   always #5 clk = ~clk;
   prng_arbiter #(.N(N), .Wout(W), .WARMUP(WU)) dut (
      .clk(clk), .rst(rst), .rnd_in(rnd_in), .req(req),
      .gnt(gnt), .rnd_out(rnd_out), .ready(ready)
`ifdef PRNG_ARB_STATS_EN
      , .grant_total(grant_total)
`endif
   );
   task automatic drive(input logic r, input logic [N-1:0] q, input logic [W-1:0] d,
                        input logic [N-1:0] g, input logic [W-1:0] ro, input logic rdy);
      rst = r;
      req = q;
      rnd_in = d;
      sb.push_back({g, ro, rdy});
   endtask
   task automatic test_reset;
      drive(1'b1, '1, 32'hdead_beef, '0, '0, 1'b0);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 3;
      if (gnt !== e.g) begin n_bad++; $display("FAIL reset gnt got %b exp %b", gnt, e.g); end
      if (rnd_out !== e.r) begin n_bad++; $display("FAIL reset rnd_out got %h exp %h", rnd_out, e.r); end
      if (ready !== e.rdy) begin n_bad++; $display("FAIL reset ready got %b exp %b", ready, e.rdy); end
      rst = 1'b0;
   endtask
   task automatic test_warmup(input int base);
      for (int k = 0; k <= WU; k++) begin
         drive(1'b0, '1, W'(base + k), (k == WU) ? 4'b0001 : 4'b0000,
               (k == WU) ? W'(base + WU) : '0, k >= WU - 1);
         @(negedge clk);
         e = sb.pop_front();
         n_cmp += 3;
         if (gnt !== e.g) begin n_bad++; $display("FAIL warmup[%0d] gnt got %b exp %b", k, gnt, e.g); end
         if (rnd_out !== e.r) begin n_bad++; $display("FAIL warmup[%0d] rnd_out got %h exp %h", k, rnd_out, e.r); end
         if (ready !== e.rdy) begin n_bad++; $display("FAIL warmup[%0d] ready got %b exp %b", k, ready, e.rdy); end
      end
   endtask
   task automatic test_round_robin;
      prev_g = gnt;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, '1, W'(200 + i), N'(1 << ((i + 1) % N)), W'(200 + i), 1'b1);
         @(negedge clk);
         e = sb.pop_front();
         n_cmp += 3;
         if (gnt !== e.g) begin n_bad++; $display("FAIL rr[%0d] gnt got %b exp %b", i, gnt, e.g); end
         if (rnd_out !== e.r) begin n_bad++; $display("FAIL rr[%0d] rnd_out got %h exp %h", i, rnd_out, e.r); end
         if ((gnt & prev_g) !== '0) begin n_bad++; $display("FAIL rr[%0d] repeat gnt got %b prev %b", i, gnt, prev_g); end
         prev_g = gnt;
      end
   endtask
   task automatic test_sparse;
      logic [N-1:0] q [11] = '{4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0010,
                               4'b0010, 4'b0010, 4'b0001, 4'b1001, 4'b1001};
      logic [N-1:0] g [11] = '{4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0010,
                               4'b0000, 4'b0010, 4'b0001, 4'b1000, 4'b0001};
      int r [11] = '{203, 301, 301, 303, 303, 305, 305, 307, 308, 309, 310};
      for (int i = 0; i < 11; i++) begin
         drive(1'b0, q[i], W'(300 + i), g[i], W'(r[i]), 1'b1);
         @(negedge clk);
         e = sb.pop_front();
         n_cmp += 3;
         if (gnt !== e.g) begin n_bad++; $display("FAIL sparse[%0d] gnt got %b exp %b", i, gnt, e.g); end
         if (rnd_out !== e.r) begin n_bad++; $display("FAIL sparse[%0d] rnd_out got %h exp %h", i, rnd_out, e.r); end
         if (ready !== e.rdy) begin n_bad++; $display("FAIL sparse[%0d] ready got %b exp %b", i, ready, e.rdy); end
      end
   endtask
   task automatic test_uniqueness;
      for (int i = 0; i < 100; i++) begin
         drive(1'b0, '1, W'(i), N'(1 << ((i + 1) % N)), W'(i), 1'b1);
         @(negedge clk);
         e = sb.pop_front();
         n_cmp += 2;
         if (gnt !== e.g) begin n_bad++; $display("FAIL uniq[%0d] gnt got %b exp %b", i, gnt, e.g); end
         if (rnd_out !== e.r) begin n_bad++; $display("FAIL uniq[%0d] rnd_out got %h exp %h", i, rnd_out, e.r); end
         if (i > 0) begin
            n_cmp++;
            if (!(rnd_out > prev_r)) begin n_bad++; $display("FAIL uniq[%0d] order got %h after %h", i, rnd_out, prev_r); end
         end
         prev_r = rnd_out;
      end
   endtask
   task automatic test_reset_midrun;
      test_reset();
      test_warmup(600);
   endtask
`ifdef PRNG_ARB_STATS_EN
   task automatic test_stats;
      test_reset();
      n_cmp++;
      if (grant_total !== 32'd0) begin n_bad++; $display("FAIL stats reset got %0d exp 0", grant_total); end
      test_warmup(700);
      for (int i = 0; i < 36; i++) begin
         drive(1'b0, '1, W'(800 + i), N'(1 << ((i + 1) % N)), W'(800 + i), 1'b1);
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if (gnt !== e.g) begin n_bad++; $display("FAIL stats[%0d] gnt got %b exp %b", i, gnt, e.g); end
      end
      drive(1'b0, '0, W'(900), '0, W'(835), 1'b1);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 2;
      if (gnt !== e.g) begin n_bad++; $display("FAIL stats idle gnt got %b exp %b", gnt, e.g); end
      if (grant_total !== 32'd37) begin n_bad++; $display("FAIL stats total got %0d exp 37", grant_total); end
      drive(1'b1, '0, '0, '0, '0, 1'b0);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if (grant_total !== 32'd0) begin n_bad++; $display("FAIL stats after rst got %0d exp 0", grant_total); end
      rst = 1'b0;
   endtask
`endif
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
   initial begin
      @(negedge clk);
      test_reset();
      test_warmup(100);
      test_round_robin();
      test_sparse();
      test_uniqueness();
      test_reset_midrun();
`ifdef PRNG_ARB_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
